// File: rtl/conv_encoder_if.sv
// conv_encoder_if: bit-in / symbol-out handshake bundle of the convolutional encoder.
interface conv_encoder_if;
    logic       valid_in;
    logic       ready_in;
    logic       data_in;
    logic       valid_out;
    logic       ready_out;
    logic [1:0] code_out;
    logic       sof;
    logic       eof;
    modport master (output valid_in, data_in, ready_out, input ready_in, valid_out, code_out, sof, eof);
    modport slave  (input valid_in, data_in, ready_out, output ready_in, valid_out, code_out, sof, eof);
endinterface

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 framed convolutional encoder with zero-tail termination,
// registered output slot with backpressure and a synchronous frame-abort refresh.
module conv_encoder #(
    parameter int         FRAME_LEN = 8,
    parameter int         CNT_W     = 4,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 refresh,
    conv_encoder_if.slave        b,
    output logic [1:0]           enc_state,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
    state_t st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic tail2, slot, acc, tail_go, load, d;
    logic [2:0] w;
    always_comb begin
        slot       = !b.valid_out || b.ready_out;
        b.ready_in = (st != TAIL) && slot && !refresh;
        acc        = b.valid_in && b.ready_in;
        tail_go    = (st == TAIL) && slot && !refresh;
        load       = acc || tail_go;
        d          = (st == TAIL) ? 1'b0 : b.data_in;
        w          = {d, enc_state};
        cnt_inc    = cnt + 1'b1;
        st_nx      = st;
        if (acc)
            st_nx = (cnt_inc == CNT_W'(FRAME_LEN)) ? TAIL : DATA;
        else if (tail_go && tail2)
            st_nx = IDLE;
    end
    assign busy = (st != IDLE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= IDLE;
        else
            st <= refresh ? IDLE : st_nx;
    end
    // tail2 marks that the first zero-tail symbol has been emitted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_state   <= 2'b00;
            cnt         <= '0;
            tail2       <= 1'b0;
            b.valid_out <= 1'b0;
            b.code_out  <= 2'b00;
            b.sof       <= 1'b0;
            b.eof       <= 1'b0;
        end else if (refresh) begin
            enc_state   <= 2'b00;
            cnt         <= '0;
            tail2       <= 1'b0;
            b.valid_out <= 1'b0;
            b.sof       <= 1'b0;
            b.eof       <= 1'b0;
        end else if (load) begin
            enc_state   <= {d, enc_state[1]};
            b.code_out  <= {^(w & G0), ^(w & G1)};
            b.valid_out <= 1'b1;
            b.sof       <= (st == IDLE);
            b.eof       <= tail_go && tail2;
            cnt         <= acc ? cnt_inc : (tail2 ? '0 : cnt);
            tail2       <= tail_go && !tail2;
        end else if (b.ready_out) begin
            b.valid_out <= 1'b0;
        end
    end
endmodule
